header_filter_fifo: RTL

- Parametrised module-header filter for the user data path. It forwards packet words (first ctrl==0 word through the EOP word) unchanged.
- Module-header words (nonzero ctrl before the packet) are forwarded only if their ctrl value is in a configurable keep-list. All other header words are dropped.
- Contains an output FIFO to decouple out_rdy back-pressure, a runtime strip enable, and drop/packet statistics.
- Sits in the user pipeline ahead of blocks that need only selected module headers.

---
 rtl/header_filter_fifo.sv | 113 +++++++++++
 1 files changed

// File: rtl/header_filter_fifo.sv
// Module-header filter with output FIFO: forwards packet words unchanged and keeps only
// header words whose ctrl value appears in KEEP_CTRL_LIST (or all words when stripping is off).
module header_filter_fifo #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_KEEP        = 1,
  parameter logic [NUM_KEEP*CTRL_WIDTH-1:0] KEEP_CTRL_LIST = 8'hFF,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  strip_en,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int PTR_W   = (FIFO_DEPTH_BITS > 0) ? FIFO_DEPTH_BITS : 1;
  localparam int CNT_W   = FIFO_DEPTH_BITS + 1;
  localparam int WORD_W  = DATA_WIDTH + CTRL_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              in_pkt;
  logic              strip_en_q;

  logic accept;
  logic ctrl_zero;
  logic is_header;
  logic list_match;
  logic keep;
  logic push;
  logic pop;

  // Explicit wrap so a single-entry FIFO (pointer never leaves 0) is handled too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    list_match = 1'b0;
    for (int i = 0; i < NUM_KEEP; i++) begin
      if (KEEP_CTRL_LIST[i*CTRL_WIDTH +: CTRL_WIDTH] != '0 &&
          KEEP_CTRL_LIST[i*CTRL_WIDTH +: CTRL_WIDTH] == in_ctrl)
        list_match = 1'b1;
    end
  end

  assign in_rdy    = (count != CNT_W'(DEPTH));
  assign accept    = in_wr && in_rdy;
  assign ctrl_zero = (in_ctrl == '0);
  assign is_header = !in_pkt && !ctrl_zero;
  assign keep      = in_pkt || ctrl_zero || !strip_en_q || list_match;
  assign push      = accept && keep;
  assign pop       = (count != '0) && out_rdy;

  // NOTE: the storage array is deliberately not reset; count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_ctrl, in_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_pkt     <= 1'b0;
      strip_en_q <= 1'b1;
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (accept) begin
        if (!in_pkt && ctrl_zero) in_pkt <= 1'b1;
        else if (in_pkt && !ctrl_zero) in_pkt <= 1'b0;
      end

      // Strip mode only changes between packets so a packet is never split by a mode change.
      if ((!in_pkt && !accept) || (accept && is_header))
        strip_en_q <= strip_en;

      if (accept && !in_pkt && ctrl_zero) pkt_count  <= pkt_count + 32'd1;
      if (accept && !keep)                drop_count <= drop_count + 32'd1;

      out_wr <= pop;
      if (pop) {out_ctrl, out_data} <= mem[rd_ptr];
    end
  end

endmodule
